spi_display_receiver: RTL and testbench
=======================================

# spi_display_receiver

Clocked SPI peripheral that is the receiving end of the stopwatch's display link. It samples the 16-bit MAX7219-style frames (MSB first; bits [11:8] address, [7:0] data) driven on MOSI/CS/clk_SPI. It decodes each completed frame into a display register file: eight digit registers plus the decode-mode, intensity, scan-limit, shutdown and display-test controls. It sits in the test harness and the on-chip loopback path as the display model, so driver output is checked at register level.

## Interface
Parameters:
- FRAME_BITS, 16, bits per valid frame
- SHUTDOWN_RST, 1, reset value of shutdown

Ports:
- clk  in  1  system clock; must be ≥ 4× clk_SPI frequency
- res  in  1  synchronous, active-high reset
- clk_SPI  in  1  serial clock from driver, idle low, data sampled on rising edge
- CS  in  1  chip select, active low
- MOSI  in  1  serial data, MSB first
- digits  out  64  digit registers 1..8 packed; digit n at [8n-1:8n-8]
- decode_mode  out  8  register 0x9
- intensity  out  4  register 0xA, data[3:0]
- scan_limit  out  3  register 0xB, data[2:0]
- shutdown  out  1  1 = display off; cleared by 0xC write with data[0]=1
- display_test  out  1  register 0xF, data[0]
- frame_valid  out  1  one-cycle pulse per accepted frame
- frame_addr  out  4  address of last accepted frame
- frame_err  out  1  one-cycle pulse on a frame with bit count ≠ FRAME_BITS

## Operation
- Reset (res=1 at a clk edge): all registers 0, except shutdown=SHUTDOWN_RST. frame_valid=0, frame_err=0, frame_addr=0, bit counter 0, FSM→IDLE. Reset mid-frame discards the partial frame with no pulse.
- FSM states:
  - IDLE: waits for the CS falling edge → SHIFT; shift register and counter clear.
  - SHIFT: each detected clk_SPI rising edge shifts MOSI into sr[0], sr←{sr[14:0],MOSI}. Counter increments and saturates at 31. CS rising edge → COMMIT.
  - COMMIT: one cycle, then → IDLE. If count==FRAME_BITS, the frame is accepted; otherwise frame_err pulses and no register changes.
- Accepted frame, decoded on sr[11:8]; sr[15:12] ignored:
  - 0x1–0x8: digit[addr] ← data
  - 0x9: decode_mode
  - 0xA: intensity
  - 0xB: scan_limit
  - 0xC: shutdown ← ~data[0]
  - 0xF: display_test ← data[0]
  - 0x0, 0xD, 0xE: no register change, frame_valid still pulses.
- frame_addr updates on every accepted frame.
- An SCK rising edge detected in the same clk cycle as the CS rising edge is discarded.
- A CS falling edge detected in the COMMIT cycle is honoured: the FSM goes directly to SHIFT with a cleared counter.
- SCK edges while CS is high are ignored.

## Timing
- With sync, every clk_SPI/CS edge is detected 3 clk cycles after the pin changes: 2 synchronizer flops plus 1 edge register.
- CS rise detected in cycle N:
  - COMMIT in N+1
  - register update, frame_valid/frame_err and frame_addr visible at N+2
  - back in IDLE at N+2
- Minimum pulse width on clk_SPI high and low, and CS high between frames, is 2 clk cycles.
- Outputs are registered; no combinational path from pins to outputs.

## Configuration
- SPI_RX_SYNC_EN defined: clk_SPI, CS and MOSI each pass through a 2-flop synchronizer before edge detection. Detection latency is 3 cycles.
- Undefined: pins feed the edge-detect register directly, for use when the driver runs on clk_div derived from clk. Detection latency is 1 cycle; all downstream timing shifts by −2.

## Structure
- Package spi_disp_pkg holds:
  - address localparams ADDR_NOOP, ADDR_DIG1..ADDR_DIG8, ADDR_DECODE, ADDR_INTENS, ADDR_SCANLIM, ADDR_SHUTDN, ADDR_TEST
  - FSM encoding IDLE/SHIFT/COMMIT
  - FRAME_BITS default
- One sub-module, spi_edge_sync: optional 2-flop sync plus rise/fall pulse outputs. It is instantiated for clk_SPI and CS; MOSI uses only its sync path.

## Test plan
- Reset, then observe outputs → digits=0, intensity=0, shutdown=1, no pulses.
- Frame 0x0C01 → shutdown=0, frame_valid one cycle at CS-rise+5 with sync, frame_addr=0xC.
- Frames 0x0107 then 0x0859 → digits[7:0]=0x07, digits[63:56]=0x59, other digits 0.
- 15-bit and 17-bit frames → frame_err pulses, no register change, frame_valid stays 0.
- res asserted after 9 bits of 0x0A0F, then a full 0x0A03 → intensity=3, exactly one frame_valid.
- Back-to-back frames 0x0A05/0x0B07 with 2-cycle CS high → intensity=5, scan_limit=7, two frame_valid pulses.

Source files
------------

// File: rtl/spi_disp_pkg.sv
// Shared constants for the SPI display receiver: register addresses, FSM encoding, frame length.
package spi_disp_pkg;

  localparam int FRAME_BITS_DFLT = 16;

  localparam logic [3:0] ADDR_NOOP    = 4'h0;
  localparam logic [3:0] ADDR_DIG1    = 4'h1;
  localparam logic [3:0] ADDR_DIG2    = 4'h2;
  localparam logic [3:0] ADDR_DIG3    = 4'h3;
  localparam logic [3:0] ADDR_DIG4    = 4'h4;
  localparam logic [3:0] ADDR_DIG5    = 4'h5;
  localparam logic [3:0] ADDR_DIG6    = 4'h6;
  localparam logic [3:0] ADDR_DIG7    = 4'h7;
  localparam logic [3:0] ADDR_DIG8    = 4'h8;
  localparam logic [3:0] ADDR_DECODE  = 4'h9;
  localparam logic [3:0] ADDR_INTENS  = 4'hA;
  localparam logic [3:0] ADDR_SCANLIM = 4'hB;
  localparam logic [3:0] ADDR_SHUTDN  = 4'hC;
  localparam logic [3:0] ADDR_TEST    = 4'hF;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SHIFT  = 2'd1;
  localparam logic [1:0] COMMIT = 2'd2;

endpackage

// File: rtl/spi_edge_sync.sv
// Optional 2-flop synchronizer (SPI_RX_SYNC_EN) followed by a level register and registered
// rise/fall pulses; level and pulses are aligned so a sampled data pin lines up with a clock edge.
module spi_edge_sync (
  input  logic i_clk,
  input  logic i_res,
  input  logic i_pin,
  output logic o_lvl,
  output logic o_rise,
  output logic o_fall
);

  logic w_smp;
  logic r_lvl;
  logic r_rise;
  logic r_fall;

`ifdef SPI_RX_SYNC_EN
  logic r_s1;
  logic r_s2;

  always_ff @(posedge i_clk) begin
    r_s1 <= i_pin;
    r_s2 <= r_s1;
  end

  assign w_smp = r_s2;
`else
  assign w_smp = i_pin;
`endif

  // The level keeps tracking the pin through reset so no stale edge fires on release.
  always_ff @(posedge i_clk) begin
    r_lvl <= w_smp;
    if (i_res) begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_rise <= w_smp & ~r_lvl;
      r_fall <= ~w_smp & r_lvl;
    end
  end

  assign o_lvl  = r_lvl;
  assign o_rise = r_rise;
  assign o_fall = r_fall;

endmodule

// File: rtl/spi_display_receiver.sv
// MAX7219-style SPI frame receiver decoding 16-bit frames into a display register file.
// SPI_RX_SYNC_EN adds 2-flop pin synchronizers (edge detection latency 3 cycles instead of 1).
module spi_display_receiver
  import spi_disp_pkg::*;
#(
  parameter int   FRAME_BITS   = FRAME_BITS_DFLT,
  parameter logic SHUTDOWN_RST = 1'b1
) (
  input  logic        clk,
  input  logic        res,
  input  logic        clk_SPI,
  input  logic        CS,
  input  logic        MOSI,
  output logic [63:0] digits,
  output logic [7:0]  decode_mode,
  output logic [3:0]  intensity,
  output logic [2:0]  scan_limit,
  output logic        shutdown,
  output logic        display_test,
  output logic        frame_valid,
  output logic [3:0]  frame_addr,
  output logic        frame_err
);

  localparam logic [4:0] L_FRAME_CNT = 5'(FRAME_BITS);

  logic w_sck_rise;
  logic w_sck_fall_unused;
  logic w_sck_lvl_unused;
  logic w_cs_rise;
  logic w_cs_fall;
  logic w_cs_lvl_unused;
  logic w_mosi;
  logic w_mosi_rise_unused;
  logic w_mosi_fall_unused;

  spi_edge_sync u_sck (
    .i_clk  (clk),
    .i_res  (res),
    .i_pin  (clk_SPI),
    .o_lvl  (w_sck_lvl_unused),
    .o_rise (w_sck_rise),
    .o_fall (w_sck_fall_unused)
  );

  spi_edge_sync u_cs (
    .i_clk  (clk),
    .i_res  (res),
    .i_pin  (CS),
    .o_lvl  (w_cs_lvl_unused),
    .o_rise (w_cs_rise),
    .o_fall (w_cs_fall)
  );

  spi_edge_sync u_mosi (
    .i_clk  (clk),
    .i_res  (res),
    .i_pin  (MOSI),
    .o_lvl  (w_mosi),
    .o_rise (w_mosi_rise_unused),
    .o_fall (w_mosi_fall_unused)
  );

  logic [1:0]  r_state;
  logic [4:0]  r_cnt;
  logic [11:0] r_sr;
  logic [63:0] r_digits;
  logic [7:0]  r_decode;
  logic [3:0]  r_intens;
  logic [2:0]  r_scan;
  logic        r_shut;
  logic        r_test;
  logic        r_valid;
  logic [3:0]  r_addr;
  logic        r_err;

  // The upper address nibble is never decoded, so only the low 12 bits are kept.
  logic [3:0] w_addr;
  logic [7:0] w_data;
  logic [5:0] w_dig_idx;

  assign w_addr    = r_sr[11:8];
  assign w_data    = r_sr[7:0];
  assign w_dig_idx = {w_addr[2:0] - 3'd1, 3'b000};

  always_ff @(posedge clk) begin
    if (res) begin
      r_state  <= IDLE;
      r_cnt    <= 5'd0;
      r_sr     <= 12'd0;
      r_digits <= 64'd0;
      r_decode <= 8'd0;
      r_intens <= 4'd0;
      r_scan   <= 3'd0;
      r_shut   <= SHUTDOWN_RST;
      r_test   <= 1'b0;
      r_valid  <= 1'b0;
      r_addr   <= 4'd0;
      r_err    <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_cs_fall) begin
            r_state <= SHIFT;
            r_cnt   <= 5'd0;
            r_sr    <= 12'd0;
          end
        end
        SHIFT: begin
          // CS rise wins over a coincident SCK rise, which is dropped.
          if (w_cs_rise) begin
            r_state <= COMMIT;
          end else if (w_sck_rise) begin
            r_sr <= {r_sr[10:0], w_mosi};
            if (r_cnt != 5'd31) begin
              r_cnt <= r_cnt + 5'd1;
            end
          end
        end
        COMMIT: begin
          if (r_cnt == L_FRAME_CNT) begin
            r_valid <= 1'b1;
            r_addr  <= w_addr;
            case (w_addr)
              ADDR_DIG1, ADDR_DIG2, ADDR_DIG3, ADDR_DIG4,
              ADDR_DIG5, ADDR_DIG6, ADDR_DIG7, ADDR_DIG8:
                r_digits[w_dig_idx +: 8] <= w_data;
              ADDR_DECODE:  r_decode <= w_data;
              ADDR_INTENS:  r_intens <= w_data[3:0];
              ADDR_SCANLIM: r_scan   <= w_data[2:0];
              ADDR_SHUTDN:  r_shut   <= ~w_data[0];
              ADDR_TEST:    r_test   <= w_data[0];
              default: ;
            endcase
          end else begin
            r_err <= 1'b1;
          end
          if (w_cs_fall) begin
            r_state <= SHIFT;
            r_cnt   <= 5'd0;
            r_sr    <= 12'd0;
          end else begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign digits       = r_digits;
  assign decode_mode  = r_decode;
  assign intensity    = r_intens;
  assign scan_limit   = r_scan;
  assign shutdown     = r_shut;
  assign display_test = r_test;
  assign frame_valid  = r_valid;
  assign frame_addr   = r_addr;
  assign frame_err    = r_err;

endmodule

// File: tb/tb_spi_display_receiver.sv
// Directed bench for spi_display_receiver: vector table of frames plus reset, back-to-back and edge-collision sequences.
module tb_spi_display_receiver;

`ifdef SPI_RX_SYNC_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 3;
`endif

  logic        clk = 1'b0;
  logic        res;
  logic        clk_SPI;
  logic        CS;
  logic        MOSI;
  logic [63:0] digits;
  logic [7:0]  decode_mode;
  logic [3:0]  intensity;
  logic [2:0]  scan_limit;
  logic        shutdown;
  logic        display_test;
  logic        frame_valid;
  logic [3:0]  frame_addr;
  logic        frame_err;

  spi_display_receiver dut (
    .clk          (clk),
    .res          (res),
    .clk_SPI      (clk_SPI),
    .CS           (CS),
    .MOSI         (MOSI),
    .digits       (digits),
    .decode_mode  (decode_mode),
    .intensity    (intensity),
    .scan_limit   (scan_limit),
    .shutdown     (shutdown),
    .display_test (display_test),
    .frame_valid  (frame_valid),
    .frame_addr   (frame_addr),
    .frame_err    (frame_err)
  );

  always #5 clk = ~clk;

  int n_cmp   = 0;
  int n_fail  = 0;
  int n_valid = 0;
  int n_err   = 0;

  always @(negedge clk) begin
    if (frame_valid) n_valid++;
    if (frame_err)   n_err++;
  end

  typedef struct {
    logic [31:0] frm;
    int          nb;
    logic [63:0] dig;
    logic [7:0]  dec;
    logic [3:0]  inten;
    logic [2:0]  scan;
    logic        shut;
    logic        test;
    logic [3:0]  addr;
    int          dv;
    int          de;
  } vec_t;

  vec_t vecs[14];

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Ends with CS raised in the current cycle; extra_sck raises SCK together with CS.
  task automatic send_frame(input logic [31:0] val, input int nbits, input bit extra_sck);
    CS = 1'b0;
    tick(3);
    for (int i = nbits - 1; i >= 0; i--) begin
      MOSI = val[i];
      tick(2);
      clk_SPI = 1'b1;
      tick(2);
      clk_SPI = 1'b0;
    end
    tick(2);
    CS = 1'b1;
    if (extra_sck) begin
      clk_SPI = 1'b1;
      tick(2);
      clk_SPI = 1'b0;
    end
  endtask

  initial begin
    int v0;
    int e0;
    res = 1'b1; clk_SPI = 1'b0; CS = 1'b1; MOSI = 1'b0;

    vecs[0]  = '{32'h0107, 16, 64'h0000000000000007, 8'h00, 4'h0, 3'd0, 1'b0, 1'b0, 4'h1, 1, 0};
    vecs[1]  = '{32'h0859, 16, 64'h5900000000000007, 8'h00, 4'h0, 3'd0, 1'b0, 1'b0, 4'h8, 1, 0};
    vecs[2]  = '{32'h0A05, 15, 64'h5900000000000007, 8'h00, 4'h0, 3'd0, 1'b0, 1'b0, 4'h8, 0, 1};
    vecs[3]  = '{32'h0A05, 17, 64'h5900000000000007, 8'h00, 4'h0, 3'd0, 1'b0, 1'b0, 4'h8, 0, 1};
    vecs[4]  = '{32'h09FF, 16, 64'h5900000000000007, 8'hFF, 4'h0, 3'd0, 1'b0, 1'b0, 4'h9, 1, 0};
    vecs[5]  = '{32'h0B03, 16, 64'h5900000000000007, 8'hFF, 4'h0, 3'd3, 1'b0, 1'b0, 4'hB, 1, 0};
    vecs[6]  = '{32'h0F01, 16, 64'h5900000000000007, 8'hFF, 4'h0, 3'd3, 1'b0, 1'b1, 4'hF, 1, 0};
    vecs[7]  = '{32'h0F00, 16, 64'h5900000000000007, 8'hFF, 4'h0, 3'd3, 1'b0, 1'b0, 4'hF, 1, 0};
    vecs[8]  = '{32'h0D55, 16, 64'h5900000000000007, 8'hFF, 4'h0, 3'd3, 1'b0, 1'b0, 4'hD, 1, 0};
    vecs[9]  = '{32'hF3AA, 16, 64'h5900000000AA0007, 8'hFF, 4'h0, 3'd3, 1'b0, 1'b0, 4'h3, 1, 0};
    vecs[10] = '{32'h0C00, 16, 64'h5900000000AA0007, 8'hFF, 4'h0, 3'd3, 1'b1, 1'b0, 4'hC, 1, 0};
    vecs[11] = '{32'h0A1F, 16, 64'h5900000000AA0007, 8'hFF, 4'hF, 3'd3, 1'b1, 1'b0, 4'hA, 1, 0};
    vecs[12] = '{32'h0C01, 16, 64'h5900000000AA0007, 8'hFF, 4'hF, 3'd3, 1'b0, 1'b0, 4'hC, 1, 0};
    vecs[13] = '{32'h0000, 16, 64'h5900000000AA0007, 8'hFF, 4'hF, 3'd3, 1'b0, 1'b0, 4'h0, 1, 0};

    tick(5);
    res = 1'b0;
    tick(2);
    check("rst_digits", digits, 64'h0);
    check("rst_decode", decode_mode, 64'h0);
    check("rst_intensity", intensity, 64'h0);
    check("rst_scan", scan_limit, 64'h0);
    check("rst_shutdown", shutdown, 64'h1);
    check("rst_test", display_test, 64'h0);
    check("rst_addr", frame_addr, 64'h0);
    check("rst_valid", frame_valid, 64'h0);
    check("rst_err", frame_err, 64'h0);

    // First frame: exact frame_valid timing relative to CS rise
    send_frame(32'h0C01, 16, 1'b0);
    for (int k = 1; k <= LAT + 1; k++) begin
      tick(1);
      check($sformatf("lat_valid_c%0d", k), frame_valid, (k == LAT) ? 64'h1 : 64'h0);
    end
    tick(4);
    check("c01_shutdown", shutdown, 64'h0);
    check("c01_addr", frame_addr, 64'hC);
    check("c01_vcount", n_valid, 64'h1);

    for (int i = 0; i < 14; i++) begin
      v0 = n_valid;
      e0 = n_err;
      send_frame(vecs[i].frm, vecs[i].nb, 1'b0);
      tick(8);
      check($sformatf("v%0d_digits", i), digits, vecs[i].dig);
      check($sformatf("v%0d_decode", i), decode_mode, vecs[i].dec);
      check($sformatf("v%0d_intens", i), intensity, vecs[i].inten);
      check($sformatf("v%0d_scan", i), scan_limit, vecs[i].scan);
      check($sformatf("v%0d_shut", i), shutdown, vecs[i].shut);
      check($sformatf("v%0d_test", i), display_test, vecs[i].test);
      check($sformatf("v%0d_addr", i), frame_addr, vecs[i].addr);
      check($sformatf("v%0d_nvalid", i), 64'(n_valid - v0), 64'(vecs[i].dv));
      check($sformatf("v%0d_nerr", i), 64'(n_err - e0), 64'(vecs[i].de));
    end

    // SCK rising together with CS rising must not count as a 17th bit
    v0 = n_valid; e0 = n_err;
    send_frame(32'h0B05, 16, 1'b1);
    tick(8);
    check("coll_scan", scan_limit, 64'h5);
    check("coll_nvalid", 64'(n_valid - v0), 64'h1);
    check("coll_nerr", 64'(n_err - e0), 64'h0);

    // SCK toggling while CS high is ignored
    v0 = n_valid; e0 = n_err;
    for (int k = 0; k < 3; k++) begin
      clk_SPI = 1'b1; tick(3);
      clk_SPI = 1'b0; tick(3);
    end
    check("idle_sck_nvalid", 64'(n_valid - v0), 64'h0);
    check("idle_sck_nerr", 64'(n_err - e0), 64'h0);
    send_frame(32'h0B02, 16, 1'b0);
    tick(8);
    check("idle_sck_scan", scan_limit, 64'h2);
    check("idle_sck_nvalid2", 64'(n_valid - v0), 64'h1);

    // Reset after 9 bits of 0x0A0F, then a full 0x0A03
    v0 = n_valid; e0 = n_err;
    CS = 1'b0;
    tick(3);
    for (int i = 15; i >= 7; i--) begin
      MOSI = (16'h0A0F >> i) & 1'b1;
      tick(2);
      clk_SPI = 1'b1;
      tick(2);
      clk_SPI = 1'b0;
    end
    tick(1);
    res = 1'b1;
    tick(5);
    res = 1'b0;
    tick(2);
    CS = 1'b1;
    tick(8);
    check("rstmid_nvalid", 64'(n_valid - v0), 64'h0);
    check("rstmid_nerr", 64'(n_err - e0), 64'h0);
    check("rstmid_digits", digits, 64'h0);
    check("rstmid_shut", shutdown, 64'h1);
    check("rstmid_intens", intensity, 64'h0);
    send_frame(32'h0A03, 16, 1'b0);
    tick(8);
    check("rstmid_intens2", intensity, 64'h3);
    check("rstmid_addr2", frame_addr, 64'hA);
    check("rstmid_nvalid2", 64'(n_valid - v0), 64'h1);
    check("rstmid_nerr2", 64'(n_err - e0), 64'h0);

    // Back-to-back frames with CS high for exactly 2 cycles
    v0 = n_valid; e0 = n_err;
    send_frame(32'h0A05, 16, 1'b0);
    tick(2);
    send_frame(32'h0B07, 16, 1'b0);
    tick(8);
    check("b2b_intens", intensity, 64'h5);
    check("b2b_scan", scan_limit, 64'h7);
    check("b2b_addr", frame_addr, 64'hB);
    check("b2b_nvalid", 64'(n_valid - v0), 64'h2);
    check("b2b_nerr", 64'(n_err - e0), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
